// File: rtl/vote_session.sv
// rtl/vote_session.sv - sequential ballot collector: chief yes plus at least one other yes passes
module vote_session #(
    parameter int N_VOTERS = 3,
    parameter int TIMEOUT  = 16,
    parameter int IDW      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                vote_valid,
    input  logic [IDW-1:0]      vote_id,
    input  logic                vote_yes,
    output logic                vote_ready,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timed_out,
    output logic [N_VOTERS-1:0] voted_mask
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    state_t              state_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                timed_out_q;
    logic [N_VOTERS-1:0] voted_q;
    logic [N_VOTERS-1:0] yes_q;
    logic [TW-1:0]       timer_q;

    logic [N_VOTERS-1:0] sel;
    logic                accept;
    logic [N_VOTERS-1:0] voted_d;
    logic [N_VOTERS-1:0] yes_d;
    logic                all_voted;
    logic                timeout_hit;

    // sel only spans real voters, so out-of-range ids decode to zero and are dropped
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            sel[i] = (vote_id == IDW'(i));
        end
        accept      = vote_valid && ready_q && ((sel & ~voted_q) != '0);
        voted_d     = voted_q;
        yes_d       = yes_q;
        if (accept) begin
            voted_d = voted_q | sel;
            yes_d   = (yes_q & ~sel) | (vote_yes ? sel : '0);
        end
        all_voted   = &voted_d;
        timeout_hit = (timer_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            voted_q     <= '0;
            yes_q       <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_COLLECT;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                        voted_q     <= '0;
                        yes_q       <= '0;
                        timer_q     <= '0;
                    end
                end
                S_COLLECT: begin
                    voted_q <= voted_d;
                    yes_q   <= yes_d;
                    if (all_voted || timeout_hit) begin
                        state_q     <= S_DECIDE;
                        ready_q     <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= yes_d[0] && (yes_d[N_VOTERS-1:1] != '0);
                        timed_out_q <= !all_voted;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vote_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timed_out  = timed_out_q;
    assign voted_mask = voted_q;
endmodule

// File: tb/tb_vote_session.sv
// tb/tb_vote_session.sv - scoreboard bench for vote_session with directed and random sessions
module tb_vote_session;
    localparam int N   = 3;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           vote_valid = 1'b0;
    logic [IDW-1:0] vote_id = '0;
    logic           vote_yes = 1'b0;
    logic           vote_ready;
    logic           busy;
    logic           done;
    logic           pass;
    logic           timed_out;
    logic [N-1:0]   voted_mask;

    vote_session #(.N_VOTERS(N), .TIMEOUT(TO), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_id(vote_id), .vote_yes(vote_yes),
        .vote_ready(vote_ready), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .voted_mask(voted_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         pass;
        logic         tmo;
        logic [N-1:0] mask;
        int           cycle;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // per-COLLECT-cycle ballot schedule for the next session
    logic           sv[TO];
    logic [IDW-1:0] sid[TO];
    logic           syes[TO];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_sched();
        for (int k = 0; k < TO; k++) begin
            sv[k] = 1'b0; sid[k] = '0; syes[k] = 1'b0;
        end
    endtask

    task automatic set_b(input int k, input int id, input bit yes);
        sv[k] = 1'b1; sid[k] = IDW'(id); syes[k] = yes;
    endtask

    // Reference: walk the ballots in order, first ballot per valid voter wins,
    // stop once everyone voted or the last allowed cycle has passed.
    task automatic model(output exp_t e, output int kclose);
        bit voted[N];
        bit yes[N];
        int nvoted = 0;
        int others = 0;
        for (int i = 0; i < N; i++) begin voted[i] = 0; yes[i] = 0; end
        kclose = TO - 1;
        for (int k = 0; k < TO; k++) begin
            int id = int'(sid[k]);
            if (sv[k] && id < N && !voted[id]) begin
                voted[id] = 1; yes[id] = syes[k]; nvoted++;
            end
            if (nvoted == N) begin kclose = k; break; end
        end
        for (int i = 1; i < N; i++) others += int'(yes[i]);
        e.pass = yes[0] && (others > 0);
        e.tmo  = (nvoted != N);
        for (int i = 0; i < N; i++) e.mask[i] = voted[i];
        e.cycle = 0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("pass", int'(pass), int'(e.pass));
                chk("timed_out", int'(timed_out), int'(e.tmo));
                chk("voted_mask", int'(voted_mask), int'(e.mask));
                chk("done_cycle", cyc, e.cycle);
                chk("busy_in_decide", int'(busy), 1);
                chk("ready_in_decide", int'(vote_ready), 0);
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk(name, int'({vote_ready, busy, done, pass, timed_out, voted_mask}), 0);
    endtask

    // abort_at >= 0 pulls rst_n low in that COLLECT cycle instead of finishing
    task automatic run_session(input int abort_at);
        exp_t e;
        int   kc;
        model(e, kc);
        @(posedge clk); #1;
        start = 1'b1;
        vote_valid = 1'b0;
        e.cycle = cyc + 2 + kc;
        if (abort_at < 0) sbq.push_back(e);
        for (int k = 0; k <= kc; k++) begin
            @(posedge clk); #1;
            start      = 1'($urandom_range(0, 1));
            vote_valid = sv[k];
            vote_id    = sid[k];
            vote_yes   = syes[k];
            if (k == 1) chk("busy_in_collect", int'(busy), 1);
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_all_zero("abort_outputs");
                rst_n = 1'b1; start = 1'b0; vote_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        start      = 1'($urandom_range(0, 1));
        vote_valid = 1'($urandom_range(0, 1));
        vote_id    = IDW'($urandom_range(0, 3));
        vote_yes   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0; vote_valid = 1'b0;
        @(negedge clk);
        chk("pass_held", int'(pass), int'(e.pass));
        chk("timed_out_held", int'(timed_out), int'(e.tmo));
        chk("idle_not_busy", int'(busy), 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;

        clear_sched(); set_b(0, 0, 1); set_b(1, 1, 0); set_b(2, 2, 1);
        run_session(-1);
        clear_sched(); set_b(0, 0, 0); set_b(1, 1, 1); set_b(2, 2, 1);
        run_session(-1);
        clear_sched(); set_b(0, 0, 1);
        run_session(-1);
        clear_sched(); set_b(0, 1, 1); set_b(1, 1, 0); set_b(2, 3, 1);
        set_b(3, 0, 1); set_b(4, 2, 0);
        run_session(-1);
        clear_sched(); set_b(0, 0, 1); set_b(3, 1, 1); set_b(TO - 1, 2, 0);
        run_session(-1);
        clear_sched(); set_b(0, 0, 1); set_b(1, 1, 0); set_b(2, 2, 1);
        run_session(2);
        run_session(-1);

        for (int s = 0; s < 40; s++) begin
            int dens = $urandom_range(1, 9);
            clear_sched();
            for (int k = 0; k < TO; k++) begin
                if ($urandom_range(0, 9) < dens)
                    set_b(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            run_session(-1);
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
